up_down_mod_counter: RTL

UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

---
 rtl/up_down_pkg.sv | 12 +
 rtl/up_down_tc.sv | 22 ++
 rtl/up_down_mod_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/up_down_pkg.sv
// Shared definitions for the up/down modulo counter: direction encodings and default sizing.
package up_down_pkg;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam int unsigned DEF_W   = 3;
  localparam int unsigned DEF_MOD = 8;

endpackage

// File: rtl/up_down_tc.sv
// Boundary detection for the modulo counter: flags q at MOD-1 / 0 and picks the
// terminal count for the current direction.
module up_down_tc
  import up_down_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned MOD = DEF_MOD
) (
  input  logic [W-1:0] q,
  input  logic         m,
  output logic         tc,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MaxVal = W'(MOD - 1);

  assign at_max = (q == MaxVal);
  assign at_min = (q == '0);
  assign tc     = (m == DIR_DN) ? at_min : at_max;

endmodule

// File: rtl/up_down_mod_counter.sv
// Up/down modulo-MOD counter with clamped parallel load and a registered boundary pulse.
// Define UP_DOWN_SAT_EN to saturate at the boundaries instead of wrapping.
module up_down_mod_counter
  import up_down_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned MOD = DEF_MOD
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         m,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] qn,
  output logic         tc,
  output logic         ovf
);

  localparam logic [W-1:0] MaxVal = W'(MOD - 1);

  if (W < 2 || W > 16) begin : g_bad_w
    $error("up_down_mod_counter: W=%0d outside 2..16", W);
  end
  if (MOD < 2 || MOD > (32'(1) << W)) begin : g_bad_mod
    $error("up_down_mod_counter: MOD=%0d outside 2..2**W", MOD);
  end

  logic         at_max;
  logic         at_min;
  logic [W-1:0] cnt_next;
  logic [W-1:0] q_d;
  logic         ovf_d;

  up_down_tc #(
    .W  (W),
    .MOD(MOD)
  ) u_tc (
    .q     (q),
    .m     (m),
    .tc    (tc),
    .at_max(at_max),
    .at_min(at_min)
  );

  always_comb begin
    cnt_next = q;
    if (m == DIR_UP) begin
`ifdef UP_DOWN_SAT_EN
      cnt_next = at_max ? q : q + 1'b1;
`else
      cnt_next = at_max ? '0 : q + 1'b1;
`endif
    end else begin
`ifdef UP_DOWN_SAT_EN
      cnt_next = at_min ? q : q - 1'b1;
`else
      cnt_next = at_min ? MaxVal : q - 1'b1;
`endif
    end
  end

  // Load outranks counting, and a load edge never reports a boundary event.
  always_comb begin
    q_d   = q;
    ovf_d = 1'b0;
    if (ld) begin
      q_d = (d > MaxVal) ? MaxVal : d;
    end else if (en) begin
      q_d   = cnt_next;
      ovf_d = tc;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_d;
      ovf <= ovf_d;
    end
  end

  assign qn = ~q;

endmodule
